// File: rtl/bpsk_demod_v1_0_s00_axis.sv
// BPSK receive correlator: multiplies each accepted carrier sample by a local
// square-wave reference (sign of a free-running phase accumulator), integrates
// over one symbol and decides the bit from the sign of the integral.
// Optional lock detector compiled in with `define BPSK_DEMOD_LOCK_EN.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and a source holds data stable while
// valid is high and ready is low.
module bpsk_demod_v1_0_s00_axis #(
  parameter int                     PHASE_WIDTH = 16,
  parameter logic [PHASE_WIDTH-1:0] PHASE_INC   = 16'd4096,
  parameter int                     SYMBOL_LEN  = 32,
  parameter int                     ACC_WIDTH   = 32,
  parameter int                     LOCK_THRESH = 1000
) (
  input  logic        S_AXIS_ACLK,
  input  logic        S_AXIS_ARESETN,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [15:0] S_AXIS_TDATA,
  input  logic        demod_en,
  output logic        bit_tvalid,
  input  logic        bit_tready,
  output logic        bit_tdata,
  output logic        lock,
  output logic        overrun
);

  localparam int                 CNT_W    = $clog2(SYMBOL_LEN);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SYMBOL_LEN - 1);

  // Elaboration-time parameter sanity checks.
  if (ACC_WIDTH < 17 + $clog2(SYMBOL_LEN)) begin : g_bad_acc
    $error("ACC_WIDTH too small for SYMBOL_LEN");
  end
  if (LOCK_THRESH < 0) begin : g_bad_thresh
    $error("LOCK_THRESH must be non-negative");
  end

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   integ_q, integ_d;
  logic                   bit_tvalid_q, bit_tvalid_d;
  logic                   bit_tdata_q, bit_tdata_d;
  logic                   overrun_q, overrun_d;

  logic [ACC_WIDTH-1:0]   sample_ext;
  logic [ACC_WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0]   f_val;
  logic                   last;
  logic                   stall;
  logic                   accept;
  logic                   decide;

  // Correlator datapath and stall decision for the sample being offered.
  always_comb begin
    // Sign-extend first so negating -32768 stays representable.
    sample_ext = {{(ACC_WIDTH-16){S_AXIS_TDATA[15]}}, S_AXIS_TDATA};
    prod       = phase_q[PHASE_WIDTH-1] ? -sample_ext : sample_ext;
    f_val      = integ_q + prod;
    last       = (cnt_q == LAST_CNT);
    // Only the symbol-closing sample has to wait for room in the bit register.
    stall      = last & demod_en & bit_tvalid_q & ~bit_tready;
    S_AXIS_TREADY = S_AXIS_ARESETN & ~stall;
    accept     = S_AXIS_TVALID & S_AXIS_TREADY;
    decide     = accept & demod_en & last;
  end

  // Next-state for integrator, counters, bit register and overrun flag.
  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    integ_d      = integ_q;
    bit_tvalid_d = bit_tvalid_q;
    bit_tdata_d  = bit_tdata_q;
    overrun_d    = overrun_q | (stall & S_AXIS_TVALID);
    if (bit_tvalid_q & bit_tready) begin
      bit_tvalid_d = 1'b0;
    end
    if (!demod_en) begin
      // Disabled: symbol timing held at the start, samples discarded.
      phase_d = '0;
      cnt_d   = '0;
      integ_d = '0;
    end else if (accept) begin
      phase_d = phase_q + PHASE_INC;
      if (last) begin
        integ_d      = '0;
        cnt_d        = '0;
        bit_tdata_d  = f_val[ACC_WIDTH-1];
        bit_tvalid_d = 1'b1;
      end else begin
        integ_d = f_val;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      phase_q      <= '0;
      cnt_q        <= '0;
      integ_q      <= '0;
      bit_tvalid_q <= 1'b0;
      bit_tdata_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      integ_q      <= integ_d;
      bit_tvalid_q <= bit_tvalid_d;
      bit_tdata_q  <= bit_tdata_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bit_tvalid = bit_tvalid_q;
  assign bit_tdata  = bit_tdata_q;
  assign overrun    = overrun_q;

`ifdef BPSK_DEMOD_LOCK_EN
  logic [2:0]           strong_cnt_q, strong_cnt_d;
  logic                 lock_q, lock_d;
  logic [ACC_WIDTH-1:0] f_abs;
  logic                 strong;

  // Lock detector: four consecutive strong decisions raise lock.
  always_comb begin
    f_abs        = f_val[ACC_WIDTH-1] ? -f_val : f_val;
    strong       = (f_abs >= ACC_WIDTH'(LOCK_THRESH));
    strong_cnt_d = strong_cnt_q;
    lock_d       = lock_q;
    if (!demod_en) begin
      strong_cnt_d = '0;
      lock_d       = 1'b0;
    end else if (decide) begin
      if (strong) begin
        if (strong_cnt_q != 3'd4) begin
          strong_cnt_d = strong_cnt_q + 3'd1;
        end
        lock_d = (strong_cnt_q >= 3'd3);
      end else begin
        strong_cnt_d = '0;
        lock_d       = 1'b0;
      end
    end
  end

  // Lock detector registers.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      strong_cnt_q <= '0;
      lock_q       <= 1'b0;
    end else begin
      strong_cnt_q <= strong_cnt_d;
      lock_q       <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_bpsk_demod_v1_0_s00_axis.sv
// Directed bench for the BPSK correlator: reset, normal/inverted symbols,
// backpressure, enable toggling, full-scale negative input, lock behaviour.
module tb_bpsk_demod_v1_0_s00_axis;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] s_tdata;
  logic        demod_en;
  logic        bit_tvalid;
  logic        bit_tready;
  logic        bit_tdata;
  logic        lock;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;   // samples since phase 0 (mirrors expected reference phase)

  localparam logic LOCK_ON =
`ifdef BPSK_DEMOD_LOCK_EN
    1'b1;
`else
    1'b0;
`endif

  bpsk_demod_v1_0_s00_axis dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(aresetn),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .demod_en      (demod_en),
    .bit_tvalid    (bit_tvalid),
    .bit_tready    (bit_tready),
    .bit_tdata     (bit_tdata),
    .lock          (lock),
    .overrun       (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Square wave in phase with the local reference: +amp for the first half of
  // each 16-sample carrier cycle, -amp for the second half, times sgn.
  function automatic logic [15:0] sq(input int kk, input int sgn, input int amp);
    int v;
    v = ((kk % 16) < 8) ? amp : -amp;
    v = v * sgn;
    return v[15:0];
  endfunction

  // Driver: n back-to-back samples, each expected to be accepted.
  task automatic send_n(input int n, input int sgn, input int amp);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = sq(k, sgn, amp);
      tick();
      k++;
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    aresetn    = 1'b0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    demod_en   = 1'b1;
    bit_tready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_tready",  32'(s_tready),   32'd0);
    chk("rst_tvalid",  32'(bit_tvalid), 32'd0);
    chk("rst_tdata",   32'(bit_tdata),  32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
    chk("rst_lock",    32'(lock),       32'd0);
    aresetn = 1'b1;
    #1;
    chk("tready_after_release", 32'(s_tready), 32'd1);

    // Symbol 1: in-phase, F=+3200 -> bit 0, valid only after 32nd sample
    send_n(31, 1, 100);
    chk("no_early_bit", 32'(bit_tvalid), 32'd0);
    send_n(1, 1, 100);
    chk("s1_valid", 32'(bit_tvalid), 32'd1);
    chk("s1_bit",   32'(bit_tdata),  32'd0);
    chk("s1_lock",  32'(lock),       32'd0);
    tick();
    chk("s1_drained", 32'(bit_tvalid), 32'd0);

    // Symbol 2: inverted, F=-3200 -> bit 1
    send_n(32, -1, 100);
    chk("s2_valid", 32'(bit_tvalid), 32'd1);
    chk("s2_bit",   32'(bit_tdata),  32'd1);

    // Symbol 3: back to in-phase, previous bit drains on the first edge
    send_n(32, 1, 100);
    chk("s3_valid", 32'(bit_tvalid), 32'd1);
    chk("s3_bit",   32'(bit_tdata),  32'd0);
    tick();

    // Backpressure across two symbols
    bit_tready = 1'b0;
    send_n(32, 1, 100);
    chk("bpA_valid", 32'(bit_tvalid), 32'd1);
    chk("bpA_bit",   32'(bit_tdata),  32'd0);
    chk("bpA_lock",  32'(lock),       32'(LOCK_ON));
    send_n(31, -1, 100);
    chk("bpB_held_valid", 32'(bit_tvalid), 32'd1);
    chk("bpB_held_bit",   32'(bit_tdata),  32'd0);
    s_tvalid = 1'b1;
    s_tdata  = sq(k, -1, 100);
    #1;
    chk("stall_tready",    32'(s_tready), 32'd0);
    chk("pre_overrun",     32'(overrun),  32'd0);
    tick();
    chk("overrun_set",     32'(overrun),    32'd1);
    chk("stall_hold_vld",  32'(bit_tvalid), 32'd1);
    chk("stall_hold_bit",  32'(bit_tdata),  32'd0);
    chk("stall_tready2",   32'(s_tready),   32'd0);
    bit_tready = 1'b1;
    #1;
    chk("unstall_tready",  32'(s_tready), 32'd1);
    tick();
    k++;
    s_tvalid = 1'b0;
    chk("bpB_valid", 32'(bit_tvalid), 32'd1);
    chk("bpB_bit",   32'(bit_tdata),  32'd1);
    tick();
    chk("bpB_drained",    32'(bit_tvalid), 32'd0);
    chk("overrun_sticky", 32'(overrun),    32'd1);

    // demod_en dropped at sample 10 of a symbol
    send_n(10, 1, 100);
    demod_en = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 16'h7fff;
    #1;
    chk("dis_tready", 32'(s_tready), 32'd1);
    tick();
    tick();
    chk("dis_no_bit", 32'(bit_tvalid), 32'd0);
    chk("dis_lock",   32'(lock),       32'd0);
    s_tvalid = 1'b0;
    demod_en = 1'b1;
    k = 0;
    tick();
    send_n(31, -1, 100);
    chk("reen_no_partial_bit", 32'(bit_tvalid), 32'd0);
    send_n(1, -1, 100);
    chk("reen_valid", 32'(bit_tvalid), 32'd1);
    chk("reen_bit",   32'(bit_tdata),  32'd1);
    tick();

    // Full-scale negative constant: integrates to 0 -> bit 0
    for (int i = 0; i < 32; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'h8000;
      tick();
      k++;
    end
    s_tvalid = 1'b0;
    chk("min_valid", 32'(bit_tvalid), 32'd1);
    chk("min_bit",   32'(bit_tdata),  32'd0);
    chk("min_lock",  32'(lock),       32'd0);
    tick();

    // Four strong symbols then a zero-amplitude one
    send_n(32, 1, 100);
    send_n(32, -1, 100);
    send_n(32, 1, 100);
    chk("lock3", 32'(lock), 32'd0);
    send_n(32, 1, 100);
    chk("lock4",     32'(lock),      32'(LOCK_ON));
    chk("lock4_bit", 32'(bit_tdata), 32'd0);
    send_n(32, 1, 0);
    chk("zero_valid", 32'(bit_tvalid), 32'd1);
    chk("zero_bit",   32'(bit_tdata),  32'd0);
    chk("zero_lock",  32'(lock),       32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
